// File: rtl/sm_rom_loader_pkg.sv
// Shared types for the boot-time ROM loader.
// Loader FSM state encodings and default frame marker.
package sm_rom_loader_pkg;

    typedef enum logic [2:0] {
        LDR_IDLE,
        LDR_CNT_L,
        LDR_CNT_H,
        LDR_DATA,
        LDR_CHK,
        LDR_DONE,
        LDR_ERR
    } ldrState_e;

    localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

endpackage

// File: rtl/sm_rom_loader_if.sv
// Byte stream in from the UART receiver, word writes out to the ROM.
// The loader drives the ROM side (master); the environment drives rx.
interface sm_rom_loader_if #(
    parameter int ADDR_W = 6
);

    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              rom_we;
    logic [ADDR_W-1:0] rom_addr;
    logic [31:0]       rom_wdata;

    modport master (
        input  rx_valid,
        input  rx_data,
        output rom_we,
        output rom_addr,
        output rom_wdata
    );

    modport slave (
        output rx_valid,
        output rx_data,
        input  rom_we,
        input  rom_addr,
        input  rom_wdata
    );

endinterface

// File: rtl/sm_rom_loader_timeout.sv
// Inter-byte idle watchdog: reloads on clear, counts down while enabled.
// expire is raised once the full idle budget has elapsed.
module sm_rom_loader_timeout #(
    parameter int LIMIT = 100000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= CW'(LIMIT);
        end else if (enable && cnt != '0) begin
            cnt <= cnt - CW'(1);
        end
    end

    assign expire = enable && (cnt == '0);

endmodule

// File: rtl/sm_rom_loader.sv
// Boot loader: UART byte frames -> little-endian ROM words, checksum
// verified; the CPU is held in reset until a load verifies cleanly.
module sm_rom_loader
    import sm_rom_loader_pkg::*;
#(
    parameter int         ADDR_W      = 6,
    parameter int         TIMEOUT_CYC = 100000,
    parameter logic [7:0] SYNC_BYTE   = SYNC_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    sm_rom_loader_if.master bus,
    output logic            cpu_hold,
    output logic            busy,
    output logic            load_done,
    output logic            load_err
);

    localparam logic [16:0] CAP = 17'(1) << ADDR_W;

    ldrState_e         state, stateN;
    logic [7:0]        nLo, nLoN;
    logic [15:0]       nWords, nWordsN;
    logic [15:0]       wordCnt, wordCntN;
    logic [1:0]        idx, idxN;
    logic [23:0]       word, wordN;
    logic [7:0]        chk, chkN;
    logic              weN, holdN, doneN, errN;
    logic [ADDR_W-1:0] addrN;
    logic [31:0]       wdataN;
    logic [15:0]       nFull;
    logic              expire;

    sm_rom_loader_timeout #(
        .LIMIT(TIMEOUT_CYC)
    ) u_timeout (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (bus.rx_valid || state == LDR_IDLE),
        .enable(state != LDR_IDLE),
        .expire(expire)
    );

    assign nFull = {bus.rx_data, nLo};
    assign busy  = (state != LDR_IDLE);

    always_comb begin
        stateN   = state;
        nLoN     = nLo;
        nWordsN  = nWords;
        wordCntN = wordCnt;
        idxN     = idx;
        wordN    = word;
        chkN     = chk;
        weN      = 1'b0;
        addrN    = bus.rom_addr;
        wdataN   = bus.rom_wdata;
        holdN    = cpu_hold;
        doneN    = 1'b0;
        errN     = load_err;
        unique case (state)
            LDR_IDLE: begin
                if (bus.rx_valid && bus.rx_data == SYNC_BYTE) begin
                    stateN   = LDR_CNT_L;
                    holdN    = 1'b1;
                    errN     = 1'b0;
                    wordCntN = '0;
                    idxN     = '0;
                    wordN    = '0;
                    chkN     = '0;
                end
            end
            LDR_CNT_L: begin
                if (bus.rx_valid) begin
                    nLoN   = bus.rx_data;
                    stateN = LDR_CNT_H;
                end else if (expire) begin
                    stateN = LDR_ERR;
                    errN   = 1'b1;
                end
            end
            LDR_CNT_H: begin
                if (bus.rx_valid) begin
                    nWordsN = nFull;
                    if ({1'b0, nFull} > CAP) begin
                        stateN = LDR_ERR;
                        errN   = 1'b1;
                    end else if (nFull == '0) begin
                        stateN = LDR_CHK;
                    end else begin
                        stateN = LDR_DATA;
                    end
                end else if (expire) begin
                    stateN = LDR_ERR;
                    errN   = 1'b1;
                end
            end
            LDR_DATA: begin
                if (bus.rx_valid) begin
                    chkN = chk ^ bus.rx_data;
                    if (idx == 2'd3) begin
                        // Top byte completes the word; write goes out next cycle
                        weN      = 1'b1;
                        addrN    = wordCnt[ADDR_W-1:0];
                        wdataN   = {bus.rx_data, word};
                        idxN     = '0;
                        wordCntN = wordCnt + 16'd1;
                        if (wordCnt + 16'd1 == nWords) begin
                            stateN = LDR_CHK;
                        end
                    end else begin
                        wordN[{idx, 3'b000} +: 8] = bus.rx_data;
                        idxN = idx + 2'd1;
                    end
                end else if (expire) begin
                    stateN = LDR_ERR;
                    errN   = 1'b1;
                end
            end
            LDR_CHK: begin
                if (bus.rx_valid) begin
                    if (bus.rx_data == chk) begin
                        stateN = LDR_DONE;
                        doneN  = 1'b1;
                        holdN  = 1'b0;
                    end else begin
                        stateN = LDR_ERR;
                        errN   = 1'b1;
                    end
                end else if (expire) begin
                    stateN = LDR_ERR;
                    errN   = 1'b1;
                end
            end
            LDR_DONE: stateN = LDR_IDLE;
            LDR_ERR:  stateN = LDR_IDLE;
            default:  stateN = LDR_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= LDR_IDLE;
            nLo           <= '0;
            nWords        <= '0;
            wordCnt       <= '0;
            idx           <= '0;
            word          <= '0;
            chk           <= '0;
            bus.rom_we    <= 1'b0;
            bus.rom_addr  <= '0;
            bus.rom_wdata <= '0;
            cpu_hold      <= 1'b0;
            load_done     <= 1'b0;
            load_err      <= 1'b0;
        end else begin
            state         <= stateN;
            nLo           <= nLoN;
            nWords        <= nWordsN;
            wordCnt       <= wordCntN;
            idx           <= idxN;
            word          <= wordN;
            chk           <= chkN;
            bus.rom_we    <= weN;
            bus.rom_addr  <= addrN;
            bus.rom_wdata <= wdataN;
            cpu_hold      <= holdN;
            load_done     <= doneN;
            load_err      <= errN;
        end
    end

endmodule

// File: tb/tb_sm_rom_loader.sv
// Scoreboard bench for sm_rom_loader: expected writes/events are queued
// at stimulus time and popped by a negedge monitor.
module tb_sm_rom_loader;

    localparam int AW = 6;
    localparam int TO = 40;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic cpu_hold, busy, load_done, load_err;

    int nTests = 0;
    int nFail = 0;

    wr_t         expWr[$];
    int          expEvt[$];
    logic [31:0] wq[$];
    logic        prevWe = 1'b0;
    logic        prevErr = 1'b0;

    sm_rom_loader_if #(.ADDR_W(AW)) bus ();

    sm_rom_loader #(
        .ADDR_W     (AW),
        .TIMEOUT_CYC(TO),
        .SYNC_BYTE  (8'hA5)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .cpu_hold (cpu_hold),
        .busy     (busy),
        .load_done(load_done),
        .load_err (load_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string n, input logic [63:0] act,
                         input logic [63:0] exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h, required %0h", n, act, exp);
        end
    endtask

    task automatic popEvt(input int got, input string n);
        if (expEvt.size() == 0) begin
            nTests++;
            nFail++;
            $display("FAIL unexpected_%s: got event %0d, required none", n, got);
        end else begin
            check(n, 64'(got), 64'(expEvt.pop_front()));
        end
    endtask

    always @(negedge clk) begin : monitor
        wr_t e;
        if (rst_n) begin
            if (bus.rom_we) begin
                check("we_single_cycle", 64'(prevWe), 64'd0);
                if (expWr.size() == 0) begin
                    nTests++;
                    nFail++;
                    $display("FAIL unexpected_write: addr %0d data %h, required none",
                             bus.rom_addr, bus.rom_wdata);
                end else begin
                    e = expWr.pop_front();
                    check("wr_addr", 64'(bus.rom_addr), 64'(e.addr));
                    check("wr_data", 64'(bus.rom_wdata), 64'(e.data));
                end
            end
            if (load_done) popEvt(1, "load_done");
            if (load_err && !prevErr) popEvt(2, "load_err");
        end
        prevWe  = bus.rom_we;
        prevErr = load_err;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sendByte(input logic [7:0] b, input int gap);
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        step();
        bus.rx_valid = 1'b0;
        repeat (gap) step();
    endtask

    task automatic frame(input logic [15:0] n, input logic [7:0] chk,
                         input int gap, input int nBytes, input bit sendChk);
        logic [31:0] w;
        wr_t e;
        sendByte(8'hA5, gap);
        check("hold_after_sync", 64'(cpu_hold), 64'd1);
        check("busy_after_sync", 64'(busy), 64'd1);
        check("err_cleared_by_sync", 64'(load_err), 64'd0);
        sendByte(n[7:0], gap);
        sendByte(n[15:8], gap);
        for (int i = 0; i < nBytes / 4; i++) begin
            e.addr = AW'(i);
            e.data = wq[i];
            expWr.push_back(e);
        end
        for (int i = 0; i < nBytes; i++) begin
            w = wq[i / 4];
            sendByte(w[8 * (i % 4) +: 8], gap);
        end
        if (sendChk) sendByte(chk, gap);
    endtask

    initial begin
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        rst_n = 1'b0;
        repeat (2) step();
        check("rst_hold", 64'(cpu_hold), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(load_done), 64'd0);
        check("rst_err", 64'(load_err), 64'd0);
        check("rst_we", 64'(bus.rom_we), 64'd0);
        rst_n = 1'b1;
        step();

        // 1: two-word good frame, checksum A0
        wq = {32'h00500093, 32'h00100073};
        expEvt.push_back(1);
        frame(16'd2, 8'hA0, 1, 8, 1'b1);
        repeat (3) step();
        check("t1_hold", 64'(cpu_hold), 64'd0);
        check("t1_err", 64'(load_err), 64'd0);
        check("t1_busy", 64'(busy), 64'd0);

        // 2: one word, checksum off by one bit (good = 22)
        wq = {32'hDEADBEEF};
        expEvt.push_back(2);
        frame(16'd1, 8'h23, 1, 4, 1'b1);
        repeat (3) step();
        check("t2_err", 64'(load_err), 64'd1);
        check("t2_hold", 64'(cpu_hold), 64'd1);
        check("t2_busy", 64'(busy), 64'd0);

        // 3: word count one above capacity
        expEvt.push_back(2);
        frame(16'd65, 8'h00, 0, 0, 1'b0);
        check("t3_err_now", 64'(load_err), 64'd1);
        repeat (3) step();
        check("t3_hold", 64'(cpu_hold), 64'd1);
        check("t3_busy", 64'(busy), 64'd0);

        // 5: junk then empty frame
        sendByte(8'h00, 1);
        sendByte(8'hFF, 1);
        check("t5_junk_idle", 64'(busy), 64'd0);
        check("t5_junk_hold", 64'(cpu_hold), 64'd1);
        expEvt.push_back(1);
        frame(16'd0, 8'h00, 1, 0, 1'b1);
        repeat (3) step();
        check("t5_hold", 64'(cpu_hold), 64'd0);
        check("t5_err", 64'(load_err), 64'd0);

        // 4: stall after 5 data bytes
        wq = {32'h44332211, 32'h00000055};
        expEvt.push_back(2);
        frame(16'd2, 8'h00, 1, 5, 1'b0);
        for (int k = 0; k < 5 * TO && !load_err; k++) step();
        check("t4_timeout_err", 64'(load_err), 64'd1);
        repeat (3) step();
        check("t4_busy", 64'(busy), 64'd0);
        check("t4_hold", 64'(cpu_hold), 64'd1);

        // 6: back-to-back bytes, checksum 44
        wq = {32'h01020304, 32'h10203040, 32'hA0B0C0D0, 32'h0F0E0D0C};
        expEvt.push_back(1);
        frame(16'd4, 8'h44, 0, 16, 1'b1);
        repeat (3) step();
        check("t6_hold", 64'(cpu_hold), 64'd0);

        // 6b: async reset in the middle of DATA
        wq = {32'h00500093};
        frame(16'd1, 8'h00, 0, 2, 1'b0);
        check("t6b_hold_pre", 64'(cpu_hold), 64'd1);
        rst_n = 1'b0;
        #1;
        check("t6b_hold", 64'(cpu_hold), 64'd0);
        check("t6b_busy", 64'(busy), 64'd0);
        check("t6b_we", 64'(bus.rom_we), 64'd0);
        check("t6b_addr", 64'(bus.rom_addr), 64'd0);
        check("t6b_wdata", 64'(bus.rom_wdata), 64'd0);
        check("t6b_done", 64'(load_done), 64'd0);
        check("t6b_err", 64'(load_err), 64'd0);
        step();
        rst_n = 1'b1;
        repeat (5) step();
        check("wr_queue_empty", 64'(expWr.size()), 64'd0);
        check("evt_queue_empty", 64'(expEvt.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
